// File: rtl/core_tb_mem_model_if.sv
// ---------------------------------------------------------------------------
// core_tb_mem_model_if
//   Bundle of the fetch, data-access and status signals between the RV32E core
//   (master) and the bench memory model (slave).
//
//   Fetch  : instr_addr (m->s), instr_data / instr_valid (s->m)
//   Data   : mem_addr, mem_wdata, mem_wstrb, mem_we, mem_re (m->s)
//            mem_rdata, mem_ready (s->m)
//   Status : cycle_count, done, exit_code (s->m)
// ---------------------------------------------------------------------------
interface core_tb_mem_model_if #(
  parameter int unsigned XLEN = 32
);
  logic [XLEN-1:0]   instr_addr;
  logic [XLEN-1:0]   instr_data;
  logic              instr_valid;
  logic [XLEN-1:0]   mem_addr;
  logic [XLEN-1:0]   mem_wdata;
  logic [XLEN/8-1:0] mem_wstrb;
  logic              mem_we;
  logic              mem_re;
  logic [XLEN-1:0]   mem_rdata;
  logic              mem_ready;
  logic [31:0]       cycle_count;
  logic              done;
  logic [XLEN-1:0]   exit_code;

  modport master (
    output instr_addr, mem_addr, mem_wdata, mem_wstrb, mem_we, mem_re,
    input  instr_data, instr_valid, mem_rdata, mem_ready,
           cycle_count, done, exit_code
  );

  modport slave (
    input  instr_addr, mem_addr, mem_wdata, mem_wstrb, mem_we, mem_re,
    output instr_data, instr_valid, mem_rdata, mem_ready,
           cycle_count, done, exit_code
  );
endinterface

// File: rtl/core_tb_mem_model.sv
// ---------------------------------------------------------------------------
// core_tb_mem_model
//   Instruction + data memory model for the RV32E core benches. Fetch path has
//   an IFETCH_WAIT-cycle delay after every fetch address change; data path is
//   an IDLE->WAIT->RESP handshake with DMEM_WAIT wait cycles and a one-cycle
//   mem_ready pulse. Also provides a free-running cycle counter.
//
//   Optional feature macro: CORE_TB_TOHOST_EN
//     defined   : writes to TOHOST_ADDR set done (sticky) and exit_code instead
//                 of memory; reads of TOHOST_ADDR return exit_code.
//     undefined : TOHOST_ADDR is ordinary memory, done/exit_code tied to 0.
//
// Ports
//   clk  : clock, rising edge
//   rst  : synchronous reset, active-high
//   bus  : core_tb_mem_model_if.slave (fetch, data access, status outputs)
// ---------------------------------------------------------------------------
module core_tb_mem_model #(
  parameter int unsigned     XLEN        = 32,
  parameter int unsigned     DEPTH       = 1024,
  parameter int unsigned     IFETCH_WAIT = 0,
  parameter int unsigned     DMEM_WAIT   = 1,
  parameter logic [XLEN-1:0] NOP_WORD    = 32'h0000_0013,
  parameter string           INIT_FILE   = "",
  parameter logic [XLEN-1:0] TOHOST_ADDR = 32'h0000_1000
) (
  input logic               clk,
  input logic               rst,
  core_tb_mem_model_if.slave bus
);

  localparam int unsigned AW          = $clog2(DEPTH);
  localparam int unsigned NB          = XLEN / 8;
  localparam logic [3:0]  IFETCH_LOAD = 4'(IFETCH_WAIT);
  localparam logic [3:0]  DWAIT_LOAD  = (DMEM_WAIT > 0) ? 4'(DMEM_WAIT - 1) : 4'd0;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_RESP
  } state_t;

  logic [XLEN-1:0] r_mem [DEPTH];

  // ---------------------------------------------------------------- fetch
  logic [XLEN-1:0] r_last_iaddr;
  logic            r_iaddr_ok;
  logic [3:0]      r_ifetch_cnt;
  logic [XLEN-1:0] r_instr_data;
  logic            r_instr_valid;
  logic [AW-1:0]   w_iidx;

  assign w_iidx = bus.instr_addr[AW+1:2];

  // r_iaddr_ok=0 makes the first edge after reset behave like an address
  // change, so reset release costs the same latency as a new fetch address.
  // Memory writes to the fetched word are picked up on the next reload
  // without dropping instr_valid.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_last_iaddr  <= bus.instr_addr;
      r_iaddr_ok    <= 1'b0;
      r_ifetch_cnt  <= IFETCH_LOAD;
      r_instr_data  <= NOP_WORD;
      r_instr_valid <= 1'b0;
    end else begin
      r_last_iaddr <= bus.instr_addr;
      r_iaddr_ok   <= 1'b1;
      if (!r_iaddr_ok || (bus.instr_addr != r_last_iaddr)) begin
        r_ifetch_cnt  <= IFETCH_LOAD;
        r_instr_data  <= NOP_WORD;
        r_instr_valid <= 1'b0;
      end else if (r_ifetch_cnt != 4'd0) begin
        r_ifetch_cnt <= r_ifetch_cnt - 4'd1;
      end else begin
        r_instr_data  <= r_mem[w_iidx];
        r_instr_valid <= 1'b1;
      end
    end
  end

  // ----------------------------------------------------------- data FSM
  state_t          r_state;
  state_t          w_next;
  logic            w_smpl;
  logic [3:0]      r_wcnt;
  logic [XLEN-1:0] r_addr;
  logic [XLEN-1:0] r_wdata;
  logic [NB-1:0]   r_wstrb;
  logic            r_we;
  logic [XLEN-1:0] r_rdata;
  logic [XLEN-1:0] r_exit_code;
  logic            r_done;

  logic [XLEN-1:0] w_acc_addr;
  logic            w_acc_we;
  logic            w_load_rdata;
  logic            w_acc_tohost;
  logic            w_resp_tohost;
  logic [XLEN-1:0] w_rd_val;
  logic            w_commit;
  logic [AW-1:0]   w_ridx;
  logic [AW-1:0]   w_widx;

  always_comb begin
    w_next = r_state;
    w_smpl = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (bus.mem_we | bus.mem_re) begin
          w_smpl = 1'b1;
          w_next = (DMEM_WAIT == 0) ? S_RESP : S_WAIT;
        end
      end
      S_WAIT:  if (r_wcnt == 4'd0) w_next = S_RESP;
      S_RESP:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Read data is captured on the edge that enters RESP so it is stable for the
  // whole mem_ready cycle; with DMEM_WAIT=0 that edge is also the sampling edge,
  // hence the bypass from the live bus inputs.
  assign w_acc_addr   = w_smpl ? bus.mem_addr : r_addr;
  assign w_acc_we     = w_smpl ? bus.mem_we   : r_we;
  assign w_load_rdata = (w_next == S_RESP) && (r_state != S_RESP);
  assign w_ridx       = w_acc_addr[AW+1:2];
  assign w_widx       = r_addr[AW+1:2];

`ifdef CORE_TB_TOHOST_EN
  assign w_acc_tohost  = (w_acc_addr == TOHOST_ADDR);
  assign w_resp_tohost = (r_addr == TOHOST_ADDR);
`else
  assign w_acc_tohost  = 1'b0;
  assign w_resp_tohost = 1'b0;
`endif

  always_comb begin
    w_rd_val = '0;
    if (!w_acc_we) w_rd_val = w_acc_tohost ? r_exit_code : r_mem[w_ridx];
  end

  assign w_commit = !rst && (r_state == S_RESP) && r_we && !w_resp_tohost;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_wcnt  <= '0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_wstrb <= '0;
      r_we    <= 1'b0;
      r_rdata <= '0;
    end else begin
      r_state <= w_next;
      if (w_smpl) begin
        r_addr  <= bus.mem_addr;
        r_wdata <= bus.mem_wdata;
        r_wstrb <= bus.mem_wstrb;
        r_we    <= bus.mem_we;
        r_wcnt  <= DWAIT_LOAD;
      end else if ((r_state == S_WAIT) && (r_wcnt != 4'd0)) begin
        r_wcnt <= r_wcnt - 4'd1;
      end
      if (w_load_rdata) r_rdata <= w_rd_val;
    end
  end

`ifdef CORE_TB_TOHOST_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      r_exit_code <= '0;
      r_done      <= 1'b0;
    end else if ((r_state == S_RESP) && r_we && w_resp_tohost) begin
      r_exit_code <= r_wdata;
      r_done      <= 1'b1;
    end
  end
`else
  assign r_exit_code = '0;
  assign r_done      = 1'b0;
`endif

  // Memory array is deliberately outside the reset domain.
  always_ff @(posedge clk) begin
    if (w_commit) begin
      for (int unsigned b = 0; b < NB; b++) begin
        if (r_wstrb[b]) r_mem[w_widx][b*8 +: 8] <= r_wdata[b*8 +: 8];
      end
    end
  end

  // --------------------------------------------------------- cycle count
  logic [31:0] r_cycle_count;

  always_ff @(posedge clk) begin
    if (rst) r_cycle_count <= '0;
    else     r_cycle_count <= r_cycle_count + 32'd1;
  end

  // --------------------------------------------------------------- outputs
  assign bus.instr_data  = r_instr_data;
  assign bus.instr_valid = r_instr_valid;
  assign bus.mem_rdata   = r_rdata;
  assign bus.mem_ready   = (r_state == S_RESP);
  assign bus.cycle_count = r_cycle_count;
  assign bus.done        = r_done;
  assign bus.exit_code   = r_exit_code;

  // Byte offset and bits above the array size are ignored (addresses wrap).
  logic w_unused;
  assign w_unused = ^{bus.instr_addr[1:0], bus.instr_addr[XLEN-1:AW+2],
                      bus.mem_addr[1:0],   bus.mem_addr[XLEN-1:AW+2],
                      r_addr[1:0],         r_addr[XLEN-1:AW+2],
                      TOHOST_ADDR};

endmodule

// File: tb/tb_core_tb_mem_model.sv
module tb_core_tb_mem_model;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks   = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  // a: IFETCH_WAIT=3, DMEM_WAIT=2     b: IFETCH_WAIT=0, DMEM_WAIT=0
  core_tb_mem_model_if #(.XLEN(32)) bus_a ();
  core_tb_mem_model_if #(.XLEN(32)) bus_b ();

  core_tb_mem_model #(
    .XLEN(32), .DEPTH(1024), .IFETCH_WAIT(3), .DMEM_WAIT(2),
    .NOP_WORD(32'h0000_0013), .TOHOST_ADDR(32'h0000_1000)
  ) u_dut_a (.clk(clk), .rst(rst), .bus(bus_a));

  core_tb_mem_model #(
    .XLEN(32), .DEPTH(1024), .IFETCH_WAIT(0), .DMEM_WAIT(0),
    .NOP_WORD(32'h0000_0013), .TOHOST_ADDR(32'h0000_1000)
  ) u_dut_b (.clk(clk), .rst(rst), .bus(bus_b));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input bit sel_b, input logic we, input logic re,
                       input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [3:0] wstrb);
    if (sel_b) begin
      bus_b.mem_we = we; bus_b.mem_re = re; bus_b.mem_addr = addr;
      bus_b.mem_wdata = wdata; bus_b.mem_wstrb = wstrb;
    end else begin
      bus_a.mem_we = we; bus_a.mem_re = re; bus_a.mem_addr = addr;
      bus_a.mem_wdata = wdata; bus_a.mem_wstrb = wstrb;
    end
  endtask

  // Holds the request until mem_ready, then drops it and steps one more
  // cycle so the FSM is back in IDLE. lat = edges from issue to mem_ready.
  task automatic mem_op(input bit sel_b, input logic we, input logic re,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [3:0] wstrb, output logic [31:0] rdata,
                        output int lat, output logic ready_after);
    logic rdy;
    drive(sel_b, we, re, addr, wdata, wstrb);
    lat = 0;
    rdy = 1'b0;
    while (!rdy && lat < 20) begin
      tick();
      lat++;
      rdy = sel_b ? bus_b.mem_ready : bus_a.mem_ready;
    end
    rdata = sel_b ? bus_b.mem_rdata : bus_a.mem_rdata;
    drive(sel_b, 1'b0, 1'b0, '0, '0, '0);
    if (!rdy) begin
      checks++; failures++;
      $display("FAIL mem_op_timeout addr=%h got no mem_ready within %0d cycles", addr, lat);
    end
    tick();
    ready_after = sel_b ? bus_b.mem_ready : bus_a.mem_ready;
  endtask

  task automatic test_reset();
    bus_a.instr_addr = '0; bus_b.instr_addr = '0;
    drive(1'b0, 1'b0, 1'b0, '0, '0, '0);
    drive(1'b1, 1'b0, 1'b0, '0, '0, '0);
    rst = 1'b1;
    repeat (3) tick();
    checks++; if (bus_a.instr_data !== 32'h0000_0013) begin failures++; $display("FAIL reset_instr_data got=%h exp=%h", bus_a.instr_data, 32'h13); end
    checks++; if (bus_a.instr_valid !== 1'b0) begin failures++; $display("FAIL reset_instr_valid got=%b exp=0", bus_a.instr_valid); end
    checks++; if (bus_a.mem_rdata !== 32'h0) begin failures++; $display("FAIL reset_mem_rdata got=%h exp=0", bus_a.mem_rdata); end
    checks++; if (bus_a.mem_ready !== 1'b0) begin failures++; $display("FAIL reset_mem_ready got=%b exp=0", bus_a.mem_ready); end
    checks++; if (bus_a.cycle_count !== 32'd0) begin failures++; $display("FAIL reset_cycle_count got=%0d exp=0", bus_a.cycle_count); end
    checks++; if (bus_a.done !== 1'b0) begin failures++; $display("FAIL reset_done got=%b exp=0", bus_a.done); end
    checks++; if (bus_a.exit_code !== 32'h0) begin failures++; $display("FAIL reset_exit_code got=%h exp=0", bus_a.exit_code); end
    checks++; if (bus_b.instr_valid !== 1'b0) begin failures++; $display("FAIL reset_b_instr_valid got=%b exp=0", bus_b.instr_valid); end
  endtask

  task automatic test_preload();
    logic [31:0] rd; int lat; logic ra;
    rst = 1'b0;
    mem_op(1'b1, 1'b1, 1'b0, 32'h0000_0000, 32'h0050_0093, 4'hF, rd, lat, ra);
    mem_op(1'b1, 1'b1, 1'b0, 32'h0000_0008, 32'h1111_1111, 4'hF, rd, lat, ra);
    mem_op(1'b0, 1'b1, 1'b0, 32'h0000_0000, 32'h0050_0093, 4'hF, rd, lat, ra);
    mem_op(1'b0, 1'b1, 1'b0, 32'h0000_0004, 32'h00A0_0113, 4'hF, rd, lat, ra);
    mem_op(1'b0, 1'b1, 1'b0, 32'h0000_0010, 32'h1122_3344, 4'hF, rd, lat, ra);
    mem_op(1'b0, 1'b1, 1'b0, 32'h0000_0018, 32'h0BAD_F00D, 4'hF, rd, lat, ra);
  endtask

  task automatic test_fetch_nowait();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
    checks++; if (bus_b.instr_valid !== 1'b0) begin failures++; $display("FAIL fetch0_valid_c1 got=%b exp=0", bus_b.instr_valid); end
    checks++; if (bus_b.cycle_count !== 32'd1) begin failures++; $display("FAIL cycle_count_c1 got=%0d exp=1", bus_b.cycle_count); end
    tick();
    checks++; if (bus_b.instr_valid !== 1'b1) begin failures++; $display("FAIL fetch0_valid_c2 got=%b exp=1", bus_b.instr_valid); end
    checks++; if (bus_b.instr_data !== 32'h0050_0093) begin failures++; $display("FAIL fetch0_data got=%h exp=%h", bus_b.instr_data, 32'h0050_0093); end
    checks++; if (bus_b.cycle_count !== 32'd2) begin failures++; $display("FAIL cycle_count_c2 got=%0d exp=2", bus_b.cycle_count); end
  endtask

  task automatic test_fetch_wait();
    int n = 0;
    while (!bus_a.instr_valid && n < 20) begin tick(); n++; end
    checks++; if (bus_a.instr_data !== 32'h0050_0093) begin failures++; $display("FAIL fetch3_settle got=%h exp=%h", bus_a.instr_data, 32'h0050_0093); end
    bus_a.instr_addr = 32'h4;
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++; if (bus_a.instr_valid !== 1'b0 || bus_a.instr_data !== 32'h13) begin
        failures++; $display("FAIL fetch3_wait_c%0d got valid=%b data=%h exp valid=0 data=00000013", i, bus_a.instr_valid, bus_a.instr_data);
      end
    end
    tick();
    checks++; if (bus_a.instr_valid !== 1'b1 || bus_a.instr_data !== 32'h00A0_0113) begin
      failures++; $display("FAIL fetch3_done got valid=%b data=%h exp valid=1 data=00a00113", bus_a.instr_valid, bus_a.instr_data);
    end
  endtask

  task automatic test_dmem_wait();
    logic [31:0] rd; int lat; logic ra;
    mem_op(1'b0, 1'b1, 1'b0, 32'h10, 32'hDEAD_BEEF, 4'b0011, rd, lat, ra);
    checks++; if (lat !== 3) begin failures++; $display("FAIL dmem_write_latency got=%0d exp=3", lat); end
    checks++; if (ra !== 1'b0) begin failures++; $display("FAIL dmem_ready_one_shot got=%b exp=0", ra); end
    mem_op(1'b0, 1'b0, 1'b1, 32'h10, '0, '0, rd, lat, ra);
    checks++; if (rd !== 32'h1122_BEEF) begin failures++; $display("FAIL dmem_strobe_merge got=%h exp=1122beef", rd); end
    checks++; if (lat !== 3) begin failures++; $display("FAIL dmem_read_latency got=%0d exp=3", lat); end
  endtask

  task automatic test_ignore_and_rst();
    logic [31:0] rd; int lat; logic ra; int n;
    // second request issued while the first is in WAIT must be dropped
    drive(1'b0, 1'b1, 1'b0, 32'h14, 32'hAAAA_0001, 4'hF);
    tick();
    drive(1'b0, 1'b1, 1'b0, 32'h18, 32'h5555_5555, 4'hF);
    n = 0;
    while (!bus_a.mem_ready && n < 20) begin tick(); n++; end
    checks++; if (bus_a.mem_ready !== 1'b1) begin failures++; $display("FAIL ignore_ready_timeout got=%b exp=1", bus_a.mem_ready); end
    drive(1'b0, 1'b0, 1'b0, '0, '0, '0);
    tick();
    mem_op(1'b0, 1'b0, 1'b1, 32'h14, '0, '0, rd, lat, ra);
    checks++; if (rd !== 32'hAAAA_0001) begin failures++; $display("FAIL ignore_first_write got=%h exp=aaaa0001", rd); end
    mem_op(1'b0, 1'b0, 1'b1, 32'h18, '0, '0, rd, lat, ra);
    checks++; if (rd !== 32'h0BAD_F00D) begin failures++; $display("FAIL ignore_second_write got=%h exp=0badf00d", rd); end
    // we & re together: write wins, response data is zero
    mem_op(1'b0, 1'b1, 1'b1, 32'h1C, 32'h1234_5678, 4'hF, rd, lat, ra);
    checks++; if (rd !== 32'h0) begin failures++; $display("FAIL we_re_rdata got=%h exp=0", rd); end
    mem_op(1'b0, 1'b0, 1'b1, 32'h1C, '0, '0, rd, lat, ra);
    checks++; if (rd !== 32'h1234_5678) begin failures++; $display("FAIL we_re_write got=%h exp=12345678", rd); end
    // reset during WAIT discards the write and never raises mem_ready
    drive(1'b0, 1'b1, 1'b0, 32'h10, 32'hFFFF_FFFF, 4'hF);
    tick();
    rst = 1'b1;
    drive(1'b0, 1'b0, 1'b0, '0, '0, '0);
    n = 0;
    tick();
    if (bus_a.mem_ready) n++;
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin tick(); if (bus_a.mem_ready) n++; end
    checks++; if (n !== 0) begin failures++; $display("FAIL rst_wait_ready got=%0d pulses exp=0", n); end
    mem_op(1'b0, 1'b0, 1'b1, 32'h10, '0, '0, rd, lat, ra);
    checks++; if (rd !== 32'h1122_BEEF) begin failures++; $display("FAIL rst_wait_discard got=%h exp=1122beef", rd); end
  endtask

  task automatic test_alias_readfirst();
    logic [31:0] rd; int lat; logic ra;
    mem_op(1'b1, 1'b1, 1'b0, 32'h2000, 32'hCAFE_F00D, 4'hF, rd, lat, ra);
    checks++; if (lat !== 1) begin failures++; $display("FAIL nowait_latency got=%0d exp=1", lat); end
    mem_op(1'b1, 1'b0, 1'b1, 32'h0, '0, '0, rd, lat, ra);
    checks++; if (rd !== 32'hCAFE_F00D) begin failures++; $display("FAIL alias_wrap got=%h exp=cafef00d", rd); end
    bus_b.instr_addr = 32'h8;
    drive(1'b1, 1'b1, 1'b0, 32'h8, 32'h2222_2222, 4'hF);
    tick();
    checks++; if (bus_b.mem_ready !== 1'b1 || bus_b.instr_valid !== 1'b0) begin
      failures++; $display("FAIL readfirst_setup got ready=%b valid=%b exp ready=1 valid=0", bus_b.mem_ready, bus_b.instr_valid);
    end
    drive(1'b1, 1'b0, 1'b0, '0, '0, '0);
    tick();
    checks++; if (bus_b.instr_valid !== 1'b1 || bus_b.instr_data !== 32'h1111_1111) begin
      failures++; $display("FAIL readfirst_old got valid=%b data=%h exp valid=1 data=11111111", bus_b.instr_valid, bus_b.instr_data);
    end
    tick();
    checks++; if (bus_b.instr_valid !== 1'b1 || bus_b.instr_data !== 32'h2222_2222) begin
      failures++; $display("FAIL readfirst_new got valid=%b data=%h exp valid=1 data=22222222", bus_b.instr_valid, bus_b.instr_data);
    end
  endtask

  task automatic test_tohost();
    logic [31:0] rd; int lat; logic ra;
    logic        exp_done;
    logic [31:0] exp_exit, exp_th, exp_m0;
`ifdef CORE_TB_TOHOST_EN
    exp_done = 1'b1; exp_exit = 32'h1; exp_th = 32'h1; exp_m0 = 32'hCAFE_F00D;
`else
    exp_done = 1'b0; exp_exit = 32'h0; exp_th = 32'hCAFE_F001; exp_m0 = 32'hCAFE_F001;
`endif
    mem_op(1'b1, 1'b1, 1'b0, 32'h1000, 32'h0000_0001, 4'b0001, rd, lat, ra);
    checks++; if (bus_b.done !== exp_done) begin failures++; $display("FAIL tohost_done got=%b exp=%b", bus_b.done, exp_done); end
    checks++; if (bus_b.exit_code !== exp_exit) begin failures++; $display("FAIL tohost_exit_code got=%h exp=%h", bus_b.exit_code, exp_exit); end
    mem_op(1'b1, 1'b0, 1'b1, 32'h1000, '0, '0, rd, lat, ra);
    checks++; if (rd !== exp_th) begin failures++; $display("FAIL tohost_readback got=%h exp=%h", rd, exp_th); end
    mem_op(1'b1, 1'b0, 1'b1, 32'h0, '0, '0, rd, lat, ra);
    checks++; if (rd !== exp_m0) begin failures++; $display("FAIL tohost_mem_word got=%h exp=%h", rd, exp_m0); end
    checks++; if (bus_b.done !== exp_done) begin failures++; $display("FAIL tohost_done_sticky got=%b exp=%b", bus_b.done, exp_done); end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++; if (bus_b.done !== 1'b0 || bus_b.exit_code !== 32'h0) begin
      failures++; $display("FAIL tohost_reset got done=%b exit=%h exp done=0 exit=0", bus_b.done, bus_b.exit_code);
    end
  endtask

  initial begin
    test_reset();
    test_preload();
    test_fetch_nowait();
    test_fetch_wait();
    test_dmem_wait();
    test_ignore_and_rst();
    test_alias_readfirst();
    test_tohost();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout got=no finish exp=finish before 200000");
    $fatal(1);
  end

endmodule
